// File: rtl/maze_pkg.sv
// ============================================================================
// Module : maze_pkg
// Brief  : Shared result and FSM state types for maze monitors/scoreboards.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package maze_pkg;

  typedef enum logic [1:0] {
    RES_NONE      = 2'd0,
    RES_OBJECTIVE = 2'd1,
    RES_ERROR     = 2'd2,
    RES_TIMEOUT   = 2'd3
  } ep_result_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET_MON = 3'd1,
    ST_RUN       = 3'd2,
    ST_REPORT    = 3'd3,
    ST_DONE      = 3'd4
  } ep_state_t;

endpackage

`default_nettype wire

// File: rtl/maze_episode_ctrl.sv
// ============================================================================
// Module : maze_episode_ctrl
// Brief  : Episode sequencer: monitor reset, step budget, verdicts, tallies.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maze_episode_ctrl
  import maze_pkg::*;
#(
  parameter int MAX_STEPS    = 64,
  parameter int NUM_EPISODES = 8,
  localparam int SW = $clog2(MAX_STEPS + 1),
  localparam int EW = $clog2(NUM_EPISODES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step_valid,
  input  logic          mon_objective,
  input  logic          mon_error,
  output logic          mon_reset,
  output logic          busy,
  output logic          ep_done,
  output logic [1:0]    ep_result,
  output logic [SW-1:0] ep_steps,
  output logic [EW-1:0] pass_count,
  output logic [EW-1:0] fail_count,
  output logic          all_done
);

  ep_state_t     r_state;
  ep_result_t    r_result;
  logic [SW-1:0] r_cnt;
  logic [SW-1:0] r_steps;
  logic [EW-1:0] r_ep_idx;
  logic [EW-1:0] r_pass;
  logic [EW-1:0] r_fail;

  logic          w_at_max;
  logic          w_step_acc;
  logic [SW-1:0] w_cnt_next;

  // Counter saturates at the budget; ep_steps includes a step accepted on the verdict cycle.
  assign w_at_max   = (r_cnt == SW'(MAX_STEPS));
  assign w_step_acc = step_valid & ~w_at_max;
  assign w_cnt_next = r_cnt + SW'(w_step_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_result <= RES_NONE;
      r_cnt    <= '0;
      r_steps  <= '0;
      r_ep_idx <= '0;
      r_pass   <= '0;
      r_fail   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state  <= ST_RESET_MON;
            r_pass   <= '0;
            r_fail   <= '0;
            r_ep_idx <= '0;
            r_result <= RES_NONE;
          end
        end
        ST_RESET_MON: begin
          r_cnt   <= '0;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_cnt <= w_cnt_next;
          if (mon_error) begin
            r_result <= RES_ERROR;
            r_steps  <= w_cnt_next;
            r_state  <= ST_REPORT;
          end else if (mon_objective) begin
            r_result <= RES_OBJECTIVE;
            r_steps  <= w_cnt_next;
            r_state  <= ST_REPORT;
          end else if (w_at_max) begin
            r_result <= RES_TIMEOUT;
            r_steps  <= w_cnt_next;
            r_state  <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (r_result == RES_OBJECTIVE) r_pass <= r_pass + 1'b1;
          else                           r_fail <= r_fail + 1'b1;
          if (r_ep_idx == EW'(NUM_EPISODES - 1)) begin
            r_state <= ST_DONE;
          end else begin
            r_ep_idx <= r_ep_idx + 1'b1;
            r_state  <= ST_RESET_MON;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mon_reset  = (r_state == ST_RESET_MON);
  assign busy       = (r_state == ST_RESET_MON) || (r_state == ST_RUN) || (r_state == ST_REPORT);
  assign ep_done    = (r_state == ST_REPORT);
  assign all_done   = (r_state == ST_DONE);
  assign ep_result  = r_result;
  assign ep_steps   = r_steps;
  assign pass_count = r_pass;
  assign fail_count = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_maze_episode_ctrl.sv
// ============================================================================
// Module : tb_maze_episode_ctrl
// Brief  : Randomized scoreboard bench for maze_episode_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maze_episode_ctrl;

  localparam int MS = 4;
  localparam int NE = 3;
  localparam int SW = $clog2(MS + 1);
  localparam int EW = $clog2(NE + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          step_valid;
  logic          mon_objective;
  logic          mon_error;
  logic          mon_reset;
  logic          busy;
  logic          ep_done;
  logic [1:0]    ep_result;
  logic [SW-1:0] ep_steps;
  logic [EW-1:0] pass_count;
  logic [EW-1:0] fail_count;
  logic          all_done;

  maze_episode_ctrl #(.MAX_STEPS(MS), .NUM_EPISODES(NE)) dut (
    .clk(clk), .rst(rst), .start(start), .step_valid(step_valid),
    .mon_objective(mon_objective), .mon_error(mon_error),
    .mon_reset(mon_reset), .busy(busy), .ep_done(ep_done),
    .ep_result(ep_result), .ep_steps(ep_steps),
    .pass_count(pass_count), .fail_count(fail_count), .all_done(all_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int steps;
  } ep_exp_t;

  ep_exp_t ep_q[$];
  int      tally_q[$];
  int      vectors = 0;
  int      miscompares = 0;
  int      m_pass;
  int      m_fail;
  int      g_force_both;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT reports an episode or campaign end.
  ep_exp_t mon_e;
  int      mon_p, mon_f;
  logic    prev_all_done = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (ep_done) begin
        if (ep_q.size() == 0) check("unexpected_ep_done", 1, 0);
        else begin
          mon_e = ep_q.pop_front();
          check("ep_result", int'(ep_result), mon_e.res);
          check("ep_steps", int'(ep_steps), mon_e.steps);
        end
      end
      if (all_done && !prev_all_done) begin
        if (tally_q.size() < 2) check("unexpected_all_done", 1, 0);
        else begin
          mon_p = tally_q.pop_front();
          mon_f = tally_q.pop_front();
          check("pass_count", int'(pass_count), mon_p);
          check("fail_count", int'(fail_count), mon_f);
        end
      end
    end
    prev_all_done = all_done;
  end

  task automatic drive_junk();
    step_valid    = 1'($urandom);
    mon_objective = 1'($urandom);
    mon_error     = 1'($urandom);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mon_reset"}, int'(mon_reset), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_ep_done"}, int'(ep_done), 0);
    check({tag, "_ep_result"}, int'(ep_result), 0);
    check({tag, "_ep_steps"}, int'(ep_steps), 0);
    check({tag, "_pass"}, int'(pass_count), 0);
    check({tag, "_fail"}, int'(fail_count), 0);
    check({tag, "_all_done"}, int'(all_done), 0);
  endtask

  // Entered at the negedge of the mon_reset cycle. Returns 1 if aborted by rst.
  task automatic run_episode(input bit last, input bit abort, output bit aborted);
    int  cnt, cycles, res;
    bit  sv, er, ob, acc, done;
    ep_exp_t e;
    aborted = 1'b0;
    drive_junk();                       // stale flags while the monitor resets
    @(negedge clk);
    cnt = 0; cycles = 0; done = 1'b0;
    while (!done) begin
      if (abort && cycles == 1) begin
        rst = 1'b1;
        drive_junk();
        @(negedge clk);
        check_reset_values("abort");
        rst = 1'b0;
        aborted = 1'b1;
        return;
      end
      sv = ($urandom_range(0, 3) != 0) || (cycles > 2 * MS);
      er = ($urandom_range(0, 11) == 0);
      ob = ($urandom_range(0, 7) == 0);
      if (abort) begin er = 1'b0; ob = 1'b0; end
      if (g_force_both != 0 && cycles == 1) begin er = 1'b1; ob = 1'b1; end
      step_valid = sv; mon_error = er; mon_objective = ob;
      acc = sv && (cnt < MS);
      if (er)             res = 2;
      else if (ob)        res = 1;
      else if (cnt == MS) res = 3;
      else                res = 0;
      if (res != 0) begin
        e.res = res;
        e.steps = cnt + int'(acc);
        ep_q.push_back(e);
        if (res == 1) m_pass++; else m_fail++;
        if (last) begin
          tally_q.push_back(m_pass);
          tally_q.push_back(m_fail);
        end
        done = 1'b1;
      end
      cnt += int'(acc);
      cycles++;
      @(negedge clk);
    end
    drive_junk();                       // REPORT cycle: start/steps must be ignored
    start = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    if (last) check("all_done_timing", int'(all_done), 1);
    else      check("mon_reset_timing", int'(mon_reset), 1);
  endtask

  task automatic campaign(input bit abort_ep2, input bit force_both);
    bit aborted;
    m_pass = 0; m_fail = 0;
    start = 1'b1;
    drive_junk();
    @(negedge clk);
    start = 1'b0;
    check("start_mon_reset", int'(mon_reset), 1);
    check("start_clr_pass", int'(pass_count), 0);
    check("start_clr_fail", int'(fail_count), 0);
    check("start_clr_result", int'(ep_result), 0);
    for (int ep = 0; ep < NE; ep++) begin
      g_force_both = (force_both && ep == 0) ? 1 : 0;
      run_episode(ep == NE - 1, abort_ep2 && ep == 1, aborted);
      if (aborted) return;
    end
    g_force_both = 0;
    drive_junk();
    @(negedge clk);
    check("done_held", int'(all_done), 1);
    check("done_not_busy", int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    step_valid = 1'b0; mon_objective = 1'b0; mon_error = 1'b0;
    g_force_both = 0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    drive_junk();
    @(negedge clk);
    check("idle_ignores_steps", int'(busy), 0);
    for (int i = 0; i < 30; i++) begin
      campaign(i == 6, i == 0);
      if (i == 6) begin
        drive_junk();
        @(negedge clk);
      end
    end
    repeat (3) @(negedge clk);
    check("leftover_episodes", ep_q.size(), 0);
    check("leftover_tallies", tally_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
